// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO result registers.
// Latency: 32 RUN cycles per op; start is ignored and HI/LO writes are dropped while busy.
module muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [63:0] acc;
    logic [31:0] opb;
    logic [31:0] a_raw;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        accept;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic        is_div;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_dif;
    logic [63:0] acc_nxt;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        last;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == 5'd31);

    // Signed ops work on magnitudes; signs are reapplied once at the final step.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[31];
        b_neg     = signed_op & b[31];
        a_mag     = a_neg ? (~a + 32'd1) : a;
        b_mag     = b_neg ? (~b + 32'd1) : b;
    end

    // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        is_div  = op_r[1];
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        rem_sh  = {acc[63:32], acc[31]};
        rem_ge  = (rem_sh >= {1'b0, opb});
        rem_dif = rem_sh[31:0] - opb;
        acc_nxt = {mul_sum, acc[31:1]};
        if (is_div) begin
            if (rem_ge) begin
                acc_nxt = {rem_dif, acc[30:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[31:0], acc[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        quo_fin = neg_q ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
        rem_fin = neg_r ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
        {res_hi, res_lo} = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fin;
                res_lo = quo_fin;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            op_r     <= 2'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            a_raw    <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= 5'd0;
                        op_r     <= op;
                        acc      <= {32'd0, a_mag};
                        opb      <= b_mag;
                        a_raw    <= a;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (b == 32'd0);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Software writes lose to a start accepted on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (last) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if ((state != RUN) && !accept) begin
            if (wr_hi) begin
                hi <= wdata;
            end
            if (wr_lo) begin
                lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Randomized and directed bench for muldiv, checked every cycle against an arithmetic reference model.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [1:0]  op = 2'd0;
    logic        start = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    muldiv dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result as {hi, lo}, straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int     sx;
        int     sy;
        int     q;
        int     r;
        longint p;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Cycle model: a countdown of remaining RUN cycles plus the pending result.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    logic        chk_en = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_pend;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = ref_res(op, a, b);
                m_left = 32;
            end else begin
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("hi", {32'd0, hi}, {32'd0, m_hi});
            chk("lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        int          pulses;
        logic [63:0] r;

        // Pin the reference model to hand-computed values.
        r = ref_res(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ref_multu", r, 64'hFFFF_FFFE_0000_0001);
        r = ref_res(2'd0, 32'hFFFF_FFFD, 32'd7);
        chk("ref_mult", r, 64'hFFFF_FFFF_FFFF_FFEB);
        r = ref_res(2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("ref_div", r, 64'hFFFF_FFFF_FFFF_FFFD);
        r = ref_res(2'd3, 32'd100, 32'd0);
        chk("ref_divu0", r, 64'h0000_0064_FFFF_FFFF);

        #1 reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        // Start presented as reset releases: must be taken on the very first edge.
        #10;
        op     = 2'd1;
        a      = 32'hFFFF_FFFF;
        b      = 32'hFFFF_FFFF;
        start  = 1'b1;
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();
        start = 1'b0;
        chk("first_edge_busy", {63'd0, busy}, 64'd1);
        wait_done(n);
        chk("multu_latency", n, 32);
        chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0001);
        tick();

        launch(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);

        launch(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);

        launch(2'd3, 32'd100, 32'd0);
        wait_done(n);
        chk("divu0_latency", n, 32);
        chk("divu0_hi", {32'd0, hi}, 64'd100);
        chk("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);

        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_hi", {32'd0, hi}, 64'd0);
        chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);

        // Disturb inputs mid-run; the latched operands must win.
        launch(2'd3, 32'd10, 32'd3);
        for (int i = 0; i < 10; i++) begin
            start = ~start;
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom_range(0, 3));
            wr_lo = ~wr_lo;
            wdata = $urandom;
            tick();
        end
        start = 1'b0;
        wr_lo = 1'b0;
        wait_done(n);
        chk("divu_hi", {32'd0, hi}, 64'd1);
        chk("divu_lo", {32'd0, lo}, 64'd3);
        launch(2'd1, 32'd6, 32'd7);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_done", {63'd0, done}, 64'd0);
        wait_done(n);
        chk("b2b_lo", {32'd0, lo}, 64'd42);
        chk("b2b_hi", {32'd0, hi}, 64'd0);
        tick();

        // Abort mid-run with an asynchronous reset.
        launch(2'd3, 32'hDEAD_BEEF, 32'd17);
        for (int i = 0; i < 15; i++) tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        #3 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        wdata = 32'h1234;
        wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mthi_lo", {32'd0, lo}, 64'd0);

        // Random traffic, including occasional short async resets.
        for (int i = 0; i < 4000; i++) begin
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            start = ($urandom_range(0, 7) == 0);
            wr_hi = ($urandom_range(0, 3) == 0);
            wr_lo = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a  input  32  operand A: multiplicand or dividend.
REQ-005 b  input  32  operand B: multiplier or divisor.
REQ-006 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 start  input  1  request to start op on a and b.
REQ-008 wr_hi  input  1  write wdata into HI (mthi).
REQ-009 wr_lo  input  1  write wdata into LO (mtlo).
REQ-010 wdata  input  32  data for the HI/LO writes.
REQ-011 hi  output  32  HI register: upper product half or remainder.
REQ-012 lo  output  32  LO register: lower product half or quotient.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse when a result has been written to HI/LO.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-016 start SHALL be accepted at an edge when the state is IDLE or DONE; that edge SHALL latch a, b and op, clear the iteration counter and enter RUN.
REQ-017 start while in RUN SHALL be ignored; a, b and op changes during RUN SHALL NOT affect the result.
REQ-018 RUN SHALL perform one iteration per cycle for exactly 32 cycles, counter 0..31; the edge with counter=31 SHALL write HI/LO and enter DONE.
REQ-019 DONE SHALL return to IDLE at the next edge unless a new start is accepted there.
REQ-020 Latency: start accepted at edge E; busy high for the cycles after E through E+32; hi/lo valid and done=1 in the cycle after edge E+32.
REQ-021 MULTU SHALL use shift-add: {hi,lo} = the full 64-bit unsigned product a*b.
REQ-022 MULT SHALL multiply the magnitudes unsigned, then negate the 64-bit product (two's complement) when the operand signs differ.
REQ-023 DIVU SHALL use restoring division: lo = a/b and hi = a%b, unsigned.
REQ-024 DIV SHALL divide the magnitudes; the quotient SHALL be negated when the signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no error indication.
REQ-026 Divide by zero (DIV or DIVU) SHALL still take 32 RUN cycles and SHALL give lo=0xFFFFFFFF and hi=a.
REQ-027 wr_hi/wr_lo SHALL update HI/LO at the edge only when not in RUN; in RUN they SHALL be ignored.
REQ-028 If start is accepted at the same edge as wr_hi or wr_lo, the write SHALL be dropped.
REQ-029 wr_hi and wr_lo asserted together SHALL write both registers with wdata.
REQ-030 hi and lo SHALL hold their values from the end of an operation until the next write, completion or reset.

Reset
REQ-031 On reset assertion the block SHALL immediately force the state to IDLE, hi=0, lo=0, busy=0, done=0 and the counter to 0, regardless of clk.
REQ-032 Reset asserted during RUN SHALL abort the operation; no partial result SHALL reach HI/LO and no done pulse SHALL follow.
REQ-033 After reset is released, the first start SHALL be accepted on the first rising edge.

Verification
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 32 busy cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100 after 32 cycles; DIV 0x80000000 by -1 -> lo=0x80000000, hi=0.
REQ-037 Start DIVU 10/3, toggle start, a and wr_lo during RUN -> no effect; result lo=3, hi=1; then start asserted in DONE -> back-to-back operation accepted.
REQ-038 Assert reset at RUN cycle 15 -> hi=lo=0 and busy=0 immediately, no done pulse; then wr_hi with wdata=0x1234 in IDLE -> hi=0x1234.
